// File: rtl/cnn_pkg.sv
// Shared types and default constants for the CNN datapath.
// Holds the fc_classifier FSM state encoding and sizing defaults.
package cnn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_CMP  = 2'd2
    } fc_state_e;

    localparam int FC_DATA_WIDTH   = 8;
    localparam int FC_NUM_FEATURES = 48;
    localparam int FC_NUM_CLASSES  = 10;
    localparam int FC_ACC_WIDTH    = 24;
    localparam int FC_CLS_W        = 4;

endpackage

// File: rtl/fc_mac_unit.sv
// Unsigned-by-signed multiply-accumulate register.
// Synchronous clear takes priority over enable.
module fc_mac_unit
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = FC_DATA_WIDTH,
    parameter int ACC_WIDTH  = FC_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         en,
    input  logic        [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0]  acc
);

    localparam int PW = 2 * DATA_WIDTH + 1;

    logic signed [DATA_WIDTH:0] a_s;
    logic signed [PW-1:0]       prod;
    logic signed [ACC_WIDTH-1:0] prod_x;

    assign a_s    = {1'b0, a};
    assign prod   = a_s * b;
    assign prod_x = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_x;
        end
    end

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected classifier: time-multiplexed MAC plus running arg-max.
// Optional per-class bias is enabled by defining FC_BIAS_EN.
module fc_classifier
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH   = FC_DATA_WIDTH,
    parameter int NUM_FEATURES = FC_NUM_FEATURES,
    parameter int NUM_CLASSES  = FC_NUM_CLASSES,
    parameter int ACC_WIDTH    = FC_ACC_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      in_valid,
    input  logic [DATA_WIDTH*NUM_FEATURES-1:0]        in_features,
    output logic                                      in_taken,
    input  logic [DATA_WIDTH*NUM_FEATURES*NUM_CLASSES-1:0] weights,
`ifdef FC_BIAS_EN
    input  logic [ACC_WIDTH*NUM_CLASSES-1:0]          bias,
`endif
    output logic                                      busy,
    output logic [FC_CLS_W-1:0]                       out_class,
    output logic [ACC_WIDTH-1:0]                      out_score,
    output logic                                      out_valid
);

    localparam int FW = $clog2(NUM_FEATURES);
    localparam int CW = FC_CLS_W;

    fc_state_e                      state;
    logic [DATA_WIDTH*NUM_FEATURES-1:0] feat_q;
    logic [FW-1:0]                  f_idx;
    logic [CW-1:0]                  c_idx;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [ACC_WIDTH-1:0]    score;
    logic signed [ACC_WIDTH-1:0]    best;
    logic signed [ACC_WIDTH-1:0]    nbest;
    logic [CW-1:0]                  best_idx;
    logic [CW-1:0]                  nidx;
    logic [DATA_WIDTH-1:0]          feat_sel;
    logic signed [DATA_WIDTH-1:0]   w_sel;
    logic                           last_f;
    logic                           last_c;
    logic                           take;
    logic                           upd;

    assign feat_sel = feat_q[int'(f_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign w_sel    = weights[(int'(c_idx)*NUM_FEATURES
                              + int'(f_idx))*DATA_WIDTH +: DATA_WIDTH];

    assign last_f = (f_idx == FW'(NUM_FEATURES-1));
    assign last_c = (c_idx == CW'(NUM_CLASSES-1));

    // A new vector may also be taken on the edge that publishes a result.
    assign take = in_valid &&
                  ((state == ST_IDLE) ||
                   ((state == ST_CMP) && last_c));

`ifdef FC_BIAS_EN
    assign score = acc + $signed(bias[int'(c_idx)*ACC_WIDTH +: ACC_WIDTH]);
`else
    assign score = acc;
`endif

    assign upd   = (c_idx == '0) || (score > best);
    assign nbest = upd ? score : best;
    assign nidx  = upd ? c_idx : best_idx;

    fc_mac_unit #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk(clk),
        .rst(rst),
        .clr(state != ST_MAC),
        .en (state == ST_MAC),
        .a  (feat_sel),
        .b  (w_sel),
        .acc(acc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            feat_q    <= '0;
            f_idx     <= '0;
            c_idx     <= '0;
            best      <= '0;
            best_idx  <= '0;
            in_taken  <= 1'b0;
            busy      <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            out_valid <= 1'b0;
        end else begin
            in_taken  <= take;
            out_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (take) begin
                        feat_q <= in_features;
                        f_idx  <= '0;
                        c_idx  <= '0;
                        busy   <= 1'b1;
                        state  <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    f_idx <= last_f ? '0 : f_idx + 1'b1;
                    if (last_f) state <= ST_CMP;
                end
                ST_CMP: begin
                    best     <= nbest;
                    best_idx <= nidx;
                    f_idx    <= '0;
                    if (!last_c) begin
                        c_idx <= c_idx + 1'b1;
                        state <= ST_MAC;
                    end else begin
                        out_class <= nidx;
                        out_score <= nbest;
                        out_valid <= 1'b1;
                        c_idx     <= '0;
                        if (take) begin
                            feat_q <= in_features;
                            busy   <= 1'b1;
                            state  <= ST_MAC;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_classifier.sv
// Self-checking bench for fc_classifier (vectors, model, corner cases).
// Bias cases are built only when FC_BIAS_EN is defined.
module tb_fc_classifier;
    import cnn_pkg::*;

    localparam int DW  = 8;
    localparam int NF  = 48;
    localparam int NC  = 10;
    localparam int AW  = 24;
    localparam int LAT = NC * (NF + 1);

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic [DW*NF-1:0]      in_features;
    logic                  in_taken;
    logic [DW*NF*NC-1:0]   weights;
`ifdef FC_BIAS_EN
    logic [AW*NC-1:0]      bias;
`endif
    logic                  busy;
    logic [3:0]            out_class;
    logic [AW-1:0]         out_score;
    logic                  out_valid;

    fc_classifier dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_features(in_features),
        .in_taken   (in_taken),
        .weights    (weights),
`ifdef FC_BIAS_EN
        .bias       (bias),
`endif
        .busy       (busy),
        .out_class  (out_class),
        .out_score  (out_score),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    fp;
        int    wp;
        int    ecls;
        int    esc;
        string name;
    } vec_t;

    vec_t tbl[6];
    int feat[NF];
    int w[NC][NF];
    int b[NC];
    int checks   = 0;
    int failures = 0;
    int taken_cnt = 0;
    int ov_cnt    = 0;

    always @(negedge clk) begin
        if (in_taken) taken_cnt++;
        if (out_valid) ov_cnt++;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int score_i();
        logic signed [AW-1:0] s;
        s = out_score;
        return int'(s);
    endfunction

    task automatic apply();
        for (int f = 0; f < NF; f++)
            in_features[f*DW +: DW] = 8'(feat[f]);
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                weights[(c*NF+f)*DW +: DW] = 8'(w[c][f]);
`ifdef FC_BIAS_EN
        for (int c = 0; c < NC; c++)
            bias[c*AW +: AW] = 24'(b[c]);
`endif
    endtask

    task automatic set_pat(input int fp, input int wp);
        for (int f = 0; f < NF; f++) feat[f] = fp;
        for (int c = 0; c < NC; c++)
            for (int f = 0; f < NF; f++)
                case (wp)
                    0: w[c][f] = c;
                    1: w[c][f] = -128;
                    2: w[c][f] = (c == 2 || c == 5) ? 3 : 1;
                    3: w[c][f] = 0;
                    default: w[c][f] = (c == 7) ? -1 : -2;
                endcase
        apply();
    endtask

    task automatic model(output int cls, output int sc);
        longint s;
        int     s24;
        cls = 0;
        sc  = 0;
        for (int c = 0; c < NC; c++) begin
            s = 0;
            for (int f = 0; f < NF; f++)
                s += longint'(feat[f]) * longint'(w[c][f]);
            s += longint'(b[c]);
            s24 = int'(s & 64'hFFFFFF);
            if (s24 >= 32'h0080_0000) s24 -= 32'h0100_0000;
            if (c == 0 || s24 > sc) begin
                sc  = s24;
                cls = c;
            end
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    task automatic run(input string name, input int ecls, input int esc);
        int t0, o0, n;
        t0 = taken_cnt;
        o0 = ov_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check({name, " taken"}, int'(in_taken), 1);
        check({name, " busy"}, int'(busy), 1);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, " taken_end"}, int'(in_taken), 0);
        wait_out(n);
        check({name, " latency"}, n + 1, LAT);
        check({name, " class"}, int'(out_class), ecls);
        check({name, " score"}, score_i(), esc);
        check({name, " busy_done"}, int'(busy), 0);
        repeat (3) @(negedge clk);
        check({name, " ov_pulses"}, ov_cnt - o0, 1);
        check({name, " taken_pulses"}, taken_cnt - t0, 1);
    endtask

    initial begin
        int ecls, esc, n, t0, o0;

        tbl[0] = '{1,   0, 9, 432,      "ramp"};
        tbl[1] = '{255, 1, 0, -1566720, "neg_tie"};
        tbl[2] = '{1,   2, 2, 144,      "tie25"};
        tbl[3] = '{2,   0, 9, 864,      "ramp2"};
        tbl[4] = '{1,   3, 0, 0,        "zero_w"};
        tbl[5] = '{1,   4, 7, -48,      "neg_max"};

        for (int c = 0; c < NC; c++) b[c] = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        set_pat(0, 3);
        repeat (2) @(posedge clk);
        #1;
        check("rst taken", int'(in_taken), 0);
        check("rst busy", int'(busy), 0);
        check("rst class", int'(out_class), 0);
        check("rst score", score_i(), 0);
        check("rst valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            set_pat(tbl[i].fp, tbl[i].wp);
            run(tbl[i].name, tbl[i].ecls, tbl[i].esc);
        end

        for (int r = 0; r < 6; r++) begin
            for (int f = 0; f < NF; f++) feat[f] = int'($urandom_range(0, 255));
            for (int c = 0; c < NC; c++)
                for (int f = 0; f < NF; f++)
                    w[c][f] = int'($urandom_range(0, 255)) - 128;
`ifdef FC_BIAS_EN
            for (int c = 0; c < NC; c++)
                b[c] = int'($urandom_range(0, 400000)) - 200000;
`endif
            apply();
            model(ecls, esc);
            run($sformatf("rand%0d", r), ecls, esc);
        end
        for (int c = 0; c < NC; c++) b[c] = 0;

        set_pat(1, 0);
        t0 = taken_cnt;
        o0 = ov_cnt;
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        set_pat(2, 0);
        wait_out(n);
        check("b2b lat1", n, LAT);
        check("b2b score1", score_i(), 432);
        check("b2b retake", int'(in_taken), 1);
        check("b2b busy", int'(busy), 1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(n);
        check("b2b lat2", n, LAT);
        check("b2b class2", int'(out_class), 9);
        check("b2b score2", score_i(), 864);
        repeat (3) @(negedge clk);
        check("b2b taken_pulses", taken_cnt - t0, 2);
        check("b2b ov_pulses", ov_cnt - o0, 2);

        set_pat(1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (199) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid busy", int'(busy), 0);
        check("mid class", int'(out_class), 0);
        check("mid score", score_i(), 0);
        check("mid valid", int'(out_valid), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        o0 = ov_cnt;
        repeat (600) @(posedge clk);
        #1;
        check("mid no_valid", ov_cnt - o0, 0);
        run("after_rst", 9, 432);

`ifdef FC_BIAS_EN
        set_pat(1, 3);
        b[3] = 1000;
        apply();
        run("bias3", 3, 1000);
        b[3] = 0;
`else
        set_pat(1, 3);
        run("nobias", 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
